// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU/mux select codes and the bundle of decoded control signals.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pcEn;
        logic       irEn;
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
        logic       regDst;
        logic       memToReg;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic [2:0] aluOp;
        logic       illegal;
    } ctrl_t;

    function automatic logic isLegalOp(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: isLegalOp = 1'b1;
            default:                                   isLegalOp = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// Combinational decode of {state, opcode} into datapath controls.
// MULTICYCLE_CTRL_MEM_WAIT_EN gates the fetch enables with the memory handshake.
module multicycle_ctrl_dec
    import multicycle_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic       z,
    input  logic       memReady,
    output ctrl_t      ctrl
);

    logic fetchGo;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    assign fetchGo = memReady;
`else
    logic unusedMemReady;
    assign unusedMemReady = memReady;
    assign fetchGo        = 1'b1;
`endif

    // Everything not explicitly driven for a state stays 0
    always_comb begin
        ctrl = '0;
        case (state)
            ST_IF: begin
                ctrl.memRead = 1'b1;
                ctrl.irEn    = fetchGo;
                ctrl.pcEn    = fetchGo;
                ctrl.pcSrc   = PCSRC_ALU;
                ctrl.aluSrcB = SRCB_FOUR;
                ctrl.aluOp   = ALUOP_ADD;
            end
            ST_ID: begin
                ctrl.aluSrcB = SRCB_IMM_SH;
                ctrl.aluOp   = ALUOP_ADD;
                ctrl.illegal = !isLegalOp(op);
            end
            ST_EX: begin
                case (op)
                    OP_R: begin
                        ctrl.aluSrcA = 1'b1;
                        ctrl.aluSrcB = SRCB_REG;
                        ctrl.aluOp   = ALUOP_FUNCT;
                    end
                    OP_LW, OP_SW, OP_ADDI: begin
                        ctrl.aluSrcA = 1'b1;
                        ctrl.aluSrcB = SRCB_IMM;
                        ctrl.aluOp   = ALUOP_ADD;
                    end
                    OP_BEQ: begin
                        ctrl.aluSrcA = 1'b1;
                        ctrl.aluSrcB = SRCB_REG;
                        ctrl.aluOp   = ALUOP_SUB;
                        ctrl.pcSrc   = PCSRC_ALUOUT;
                        ctrl.pcEn    = z;
                    end
                    OP_J: begin
                        ctrl.pcEn  = 1'b1;
                        ctrl.pcSrc = PCSRC_JUMP;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                ctrl.memRead  = (op == OP_LW);
                ctrl.memWrite = (op == OP_SW);
            end
            ST_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = (op == OP_R);
                ctrl.memToReg = (op == OP_LW);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM with opcode latch and retired-instruction counter.
// Define MULTICYCLE_CTRL_MEM_WAIT_EN to stall IF and MEM on Mem_Ready.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic [5:0]       Op,
    input  logic             Mem_Ready,
    input  logic             Z,
    output logic             PC_En,
    output logic             IR_En,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUOp,
    output logic [2:0]       State,
    output logic             Illegal,
    output logic [CNT_W-1:0] Retired
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [5:0]       opLatch;
    logic [5:0]       decOp;
    logic [CNT_W-1:0] retired;
    logic             memGo;
    ctrl_t            ctrl;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    assign memGo = Mem_Ready;
`else
    assign memGo = 1'b1;
`endif

    // ID looks at the live instruction register; later states use the latched copy
    assign decOp = (state == ST_ID) ? Op : opLatch;

    multicycle_ctrl_dec uDec (
        .state    (state),
        .op       (decOp),
        .z        (Z),
        .memReady (Mem_Ready),
        .ctrl     (ctrl)
    );

    // Retired bumps on the transition out of each legal instruction's last state
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= ST_IF;
            opLatch <= '0;
            retired <= '0;
        end else begin
            case (state)
                ST_IF: begin
                    if (memGo) state <= ST_ID;
                end
                ST_ID: begin
                    opLatch <= Op;
                    state   <= isLegalOp(Op) ? ST_EX : ST_IF;
                end
                ST_EX: begin
                    case (opLatch)
                        OP_LW, OP_SW: state <= ST_MEM;
                        OP_BEQ, OP_J: begin
                            state   <= ST_IF;
                            retired <= retired + CNT_ONE;
                        end
                        default: state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (memGo) begin
                        if (opLatch == OP_LW) begin
                            state <= ST_WB;
                        end else begin
                            state   <= ST_IF;
                            retired <= retired + CNT_ONE;
                        end
                    end
                end
                ST_WB: begin
                    state   <= ST_IF;
                    retired <= retired + CNT_ONE;
                end
                default: state <= ST_IF;
            endcase
        end
    end

    assign PC_En    = ctrl.pcEn;
    assign IR_En    = ctrl.irEn;
    assign MemRead  = ctrl.memRead;
    assign MemWrite = ctrl.memWrite;
    assign RegWrite = ctrl.regWrite;
    assign RegDst   = ctrl.regDst;
    assign MemToReg = ctrl.memToReg;
    assign ALUSrcA  = ctrl.aluSrcA;
    assign ALUSrcB  = ctrl.aluSrcB;
    assign PCSrc    = ctrl.pcSrc;
    assign ALUOp    = ctrl.aluOp;
    assign Illegal  = ctrl.illegal;
    assign State    = state;
    assign Retired  = retired;

endmodule
